// File: rtl/reg_pipe_pkg.sv
// Shared sizing helpers and types for the elastic pipeline register.
// Stage struct width follows `REG_PIPE_WIDTH (defaults to 18).
`ifndef REG_PIPE_WIDTH
`define REG_PIPE_WIDTH 18
`endif

package reg_pipe_pkg;

    localparam int unsigned DefaultWidth = `REG_PIPE_WIDTH;
    localparam int unsigned DefaultDepth = 1;

    typedef struct packed {
        logic                       v;
        logic [`REG_PIPE_WIDTH-1:0] d;
    } stage_t;

    // Occupancy counter width; kept at least 1 so a zero-depth build still has a port.
    function automatic int unsigned occ_w(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid-tagged register stage of the elastic pipeline.
// Data only loads when the incoming tag is set, so bubbles never disturb held data.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             go_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr_i) begin
            v_d = 1'b0;
        end else if (go_i) begin
            v_d = v_i;
            if (v_i) begin
                d_d = d_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/reg_pipe_elastic.sv
// Elastic DEPTH-stage pipeline register with valid/ready backpressure and bubble collapsing.
// Define REG_PIPE_OCC_EN to drive occupancy from a popcount of the stage tags; otherwise it is 0.
module reg_pipe_elastic
    import reg_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_enable,
    input  logic                    sclr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [occ_w(DEPTH)-1:0] occupancy
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = clk ^ rst_n ^ clk_enable ^ sclr;

        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
        assign occupancy = '0;
    end else begin : g_pipe
        logic             run;
        logic [DEPTH-1:0] go;
        logic [DEPTH-1:0] stage_v;
        logic [WIDTH-1:0] stage_d [DEPTH];

        assign run = clk_enable & ~sclr;

        // Ready ripples back from the output; any empty stage re-opens the chain behind it.
        always_comb begin
            logic chain;
            go    = '0;
            chain = out_ready;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                chain = ~stage_v[i] | chain;
                go[i] = run & chain;
            end
        end

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             v_in;
            logic [WIDTH-1:0] d_in;

            if (i == 0) begin : g_head
                assign v_in = in_valid;
                assign d_in = in_data;
            end else begin : g_body
                assign v_in = stage_v[i-1];
                assign d_in = stage_d[i-1];
            end

            reg_pipe_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk  (clk),
                .rst_n(rst_n),
                .clr_i(sclr),
                .go_i (go[i]),
                .v_i  (v_in),
                .d_i  (d_in),
                .v_o  (stage_v[i]),
                .d_o  (stage_d[i])
            );
        end

        assign in_ready  = go[0];
        assign out_valid = stage_v[DEPTH-1];
        assign out_data  = stage_d[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
        localparam int unsigned OccW = occ_w(DEPTH);

        always_comb begin
            occupancy = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                occupancy = occupancy + OccW'(stage_v[i]);
            end
        end
`else
        assign occupancy = '0;
`endif
    end

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Directed self-checking bench: DEPTH=3 and DEPTH=4 pipelines plus a DEPTH=0 bypass instance.
module tb_reg_pipe_elastic;
    import reg_pipe_pkg::*;

    localparam int unsigned W = 18;
`ifdef REG_PIPE_OCC_EN
    localparam bit OccEn = 1'b1;
`else
    localparam bit OccEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         a_en, a_sclr, a_iv, a_ir, a_ov, a_or;
    logic [W-1:0] a_id, a_od;
    logic [1:0]   a_occ;
    logic         b_en, b_sclr, b_iv, b_ir, b_ov, b_or;
    logic [W-1:0] b_id, b_od;
    logic [2:0]   b_occ;
    logic         z_en, z_sclr, z_iv, z_ir, z_ov, z_or;
    logic [W-1:0] z_id, z_od;
    logic [0:0]   z_occ;

    int total = 0;
    int bad   = 0;

    reg_pipe_elastic #(.WIDTH(W), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .clk_enable(a_en), .sclr(a_sclr),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ)
    );

    reg_pipe_elastic #(.WIDTH(W), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clk_enable(b_en), .sclr(b_sclr),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ)
    );

    reg_pipe_elastic #(.WIDTH(W), .DEPTH(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .clk_enable(z_en), .sclr(z_sclr),
        .in_valid(z_iv), .in_ready(z_ir), .in_data(z_id),
        .out_valid(z_ov), .out_ready(z_or), .out_data(z_od), .occupancy(z_occ)
    );

    function automatic int occ_exp(input int n);
        return OccEn ? n : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rst_ov got=%0h want=0", a_ov); end
        total++; if (a_od !== '0) begin bad++; $display("FAIL rst_od got=%0h want=0", a_od); end
        total++; if (int'(a_occ) !== 0) begin bad++; $display("FAIL rst_occ got=%0d want=0", a_occ); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        a_or = 1'b0; a_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_id = W'(i + 5);
            tick();
        end
        a_iv = 1'b0;
        total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL full_ov got=%0h want=1", a_ov); end
        total++; if (a_od !== W'(5)) begin bad++; $display("FAIL full_od got=%0h want=5", a_od); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL arst_ov got=%0h want=0", a_ov); end
        total++; if (a_od !== '0) begin bad++; $display("FAIL arst_od got=%0h want=0", a_od); end
        total++;
        if (int'(a_occ) !== 0) begin bad++; $display("FAIL arst_occ got=%0d want=0", a_occ); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        a_or = 1'b1; a_iv = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_id = W'(k);
            #1;
            total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL strm_ir k=%0d got=%0h want=1", k, a_ir); end
            tick();
            total++;
            if (a_ov !== 1'(k >= 3)) begin
                bad++; $display("FAIL strm_ov k=%0d got=%0h want=%0h", k, a_ov, k >= 3);
            end
            if (k >= 3) begin
                total++;
                if (a_od !== W'(k - 2)) begin
                    bad++; $display("FAIL strm_od k=%0d got=%0h want=%0h", k, a_od, k - 2);
                end
            end
        end
        a_iv = 1'b0;
        tick();
        total++; if (a_od !== W'(7)) begin bad++; $display("FAIL drain_od0 got=%0h want=7", a_od); end
        tick();
        total++; if (a_od !== W'(8)) begin bad++; $display("FAIL drain_od1 got=%0h want=8", a_od); end
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL drain_ov got=%0h want=0", a_ov); end
        total++; if (a_od !== W'(8)) begin bad++; $display("FAIL drain_hold got=%0h want=8", a_od); end
    endtask

    task automatic test_backpressure();
        a_or = 1'b0; a_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_id = W'(10 + i);
            #1;
            total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL bp_fill_ir i=%0d got=%0h want=1", i, a_ir); end
            tick();
        end
        a_id = W'(13);
        #1;
        total++; if (a_ir !== 1'b0) begin bad++; $display("FAIL bp_full_ir got=%0h want=0", a_ir); end
        total++;
        if (int'(a_occ) !== occ_exp(3)) begin
            bad++; $display("FAIL bp_occ got=%0d want=%0d", a_occ, occ_exp(3));
        end
        tick();
        total++; if (a_od !== W'(10)) begin bad++; $display("FAIL bp_hold got=%0h want=a", a_od); end
        a_or = 1'b1;
        #1;
        total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL bp_release_ir got=%0h want=1", a_ir); end
        tick();
        a_iv = 1'b0;
        total++; if (a_od !== W'(11)) begin bad++; $display("FAIL bp_seq0 got=%0h want=b", a_od); end
        tick();
        total++; if (a_od !== W'(12)) begin bad++; $display("FAIL bp_seq1 got=%0h want=c", a_od); end
        tick();
        total++; if (a_od !== W'(13)) begin bad++; $display("FAIL bp_seq2 got=%0h want=d", a_od); end
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h want=0", a_ov); end
    endtask

    task automatic test_bubble_collapse();
        b_or = 1'b0; b_iv = 1'b1; b_id = W'('h100);
        tick();
        b_iv = 1'b0;
        tick(); tick(); tick();
        total++; if (b_ov !== 1'b1) begin bad++; $display("FAIL bub_ov got=%0h want=1", b_ov); end
        b_iv = 1'b1; b_id = W'('h200);
        tick();
        b_iv = 1'b0;
        total++;
        if (int'(b_occ) !== occ_exp(2)) begin
            bad++; $display("FAIL bub_occ2 got=%0d want=%0d", b_occ, occ_exp(2));
        end
        tick(); tick();
        total++; if (b_od !== W'('h100)) begin bad++; $display("FAIL bub_stall_od got=%0h want=100", b_od); end
        #1;
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL bub_ir got=%0h want=1", b_ir); end
        b_iv = 1'b1; b_id = W'('h300);
        #1;
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL bub_ir_c got=%0h want=1", b_ir); end
        tick();
        b_id = W'('h400);
        #1;
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL bub_ir_d got=%0h want=1", b_ir); end
        tick();
        b_id = W'('h500);
        #1;
        total++; if (b_ir !== 1'b0) begin bad++; $display("FAIL bub_full_ir got=%0h want=0", b_ir); end
        total++;
        if (int'(b_occ) !== occ_exp(4)) begin
            bad++; $display("FAIL bub_occ4 got=%0d want=%0d", b_occ, occ_exp(4));
        end
        tick();
        b_iv = 1'b0; b_or = 1'b1;
        #1;
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL bub_shift_ir got=%0h want=1", b_ir); end
        tick();
        total++; if (b_od !== W'('h200)) begin bad++; $display("FAIL bub_seq0 got=%0h want=200", b_od); end
        tick();
        total++; if (b_od !== W'('h300)) begin bad++; $display("FAIL bub_seq1 got=%0h want=300", b_od); end
        tick();
        total++; if (b_od !== W'('h400)) begin bad++; $display("FAIL bub_seq2 got=%0h want=400", b_od); end
        tick();
        total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL bub_empty got=%0h want=0", b_ov); end
    endtask

    task automatic test_sclr();
        a_or = 1'b1; a_iv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_id = W'(20 + i);
            tick();
        end
        total++; if (a_od !== W'(20)) begin bad++; $display("FAIL sclr_pre_od got=%0h want=14", a_od); end
        a_sclr = 1'b1; a_id = W'(23);
        #1;
        total++; if (a_ir !== 1'b0) begin bad++; $display("FAIL sclr_ir got=%0h want=0", a_ir); end
        tick();
        a_sclr = 1'b0; a_iv = 1'b0;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL sclr_ov got=%0h want=0", a_ov); end
        total++; if (int'(a_occ) !== 0) begin bad++; $display("FAIL sclr_occ got=%0d want=0", a_occ); end
        total++; if (a_od !== W'(20)) begin bad++; $display("FAIL sclr_dhold got=%0h want=14", a_od); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL sclr_after i=%0d got=%0h want=0", i, a_ov); end
        end
    endtask

    task automatic test_clk_enable();
        a_or = 1'b1; a_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_id = W'(30 + i);
            tick();
        end
        a_en = 1'b0; a_id = W'(34);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (a_ir !== 1'b0) begin bad++; $display("FAIL ce_ir i=%0d got=%0h want=0", i, a_ir); end
            tick();
            total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL ce_ov i=%0d got=%0h want=1", i, a_ov); end
            total++; if (a_od !== W'(31)) begin bad++; $display("FAIL ce_od i=%0d got=%0h want=1f", i, a_od); end
        end
        total++;
        if (int'(a_occ) !== occ_exp(3)) begin
            bad++; $display("FAIL ce_occ got=%0d want=%0d", a_occ, occ_exp(3));
        end
        a_en = 1'b1;
        #1;
        total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL ce_resume_ir got=%0h want=1", a_ir); end
        tick();
        a_iv = 1'b0;
        total++; if (a_od !== W'(32)) begin bad++; $display("FAIL ce_seq0 got=%0h want=20", a_od); end
        tick();
        total++; if (a_od !== W'(33)) begin bad++; $display("FAIL ce_seq1 got=%0h want=21", a_od); end
        tick();
        total++; if (a_od !== W'(34)) begin bad++; $display("FAIL ce_seq2 got=%0h want=22", a_od); end
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL ce_empty got=%0h want=0", a_ov); end
    endtask

    task automatic test_bypass();
        logic [3:0]   iv_v;
        logic [3:0]   or_v;
        logic [3:0]   en_v;
        logic [3:0]   sc_v;
        logic [W-1:0] id_v [4];
        iv_v = 4'b0101;
        or_v = 4'b0110;
        en_v = 4'b1001;
        sc_v = 4'b1010;
        id_v[0] = 18'h15a5a; id_v[1] = 18'h00001; id_v[2] = 18'h3ffff; id_v[3] = 18'h2aaaa;
        for (int i = 0; i < 4; i++) begin
            z_iv = iv_v[i]; z_or = or_v[i]; z_en = en_v[i]; z_sclr = sc_v[i]; z_id = id_v[i];
            #1;
            total++;
            if (z_ov !== iv_v[i]) begin bad++; $display("FAIL byp_ov i=%0d got=%0h want=%0h", i, z_ov, iv_v[i]); end
            total++;
            if (z_od !== id_v[i]) begin bad++; $display("FAIL byp_od i=%0d got=%0h want=%0h", i, z_od, id_v[i]); end
            total++;
            if (z_ir !== or_v[i]) begin bad++; $display("FAIL byp_ir i=%0d got=%0h want=%0h", i, z_ir, or_v[i]); end
            total++;
            if (z_occ !== 1'b0) begin bad++; $display("FAIL byp_occ i=%0d got=%0h want=0", i, z_occ); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_en = 1'b1; a_sclr = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_id = '0;
        b_en = 1'b1; b_sclr = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_id = '0;
        z_en = 1'b0; z_sclr = 1'b0; z_iv = 1'b0; z_or = 1'b0; z_id = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_sclr();
        test_clk_enable();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
